// File: rtl/rr_mux_pkg.sv
// rr_mux_pkg: shared channel-index width helper and reset values for rr_mux_arb
package rr_mux_pkg;
  localparam bit RST_VALID = 1'b0;
  localparam int RST_DATA = 0;
  localparam int RST_CHAN = 0;
  localparam int RST_PTR = 0;
  function automatic int cw_of(input int n);
    return $clog2(n) > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arb.sv
// rr_arb: round-robin grant of the first req at or after ptr with wrap; ports req, ptr -> one-hot grant, index g
module rr_arb import rr_mux_pkg::*; #(
  parameter int NCH = 3,
  parameter int CW = cw_of(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CW-1:0]  ptr,
  output logic [NCH-1:0] grant,
  output logic [CW-1:0]  g
);
  always_comb begin
    g = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (req[i] && i < int'(ptr)) g = CW'(i);
    for (int i = NCH - 1; i >= 0; i--)
      if (req[i] && i >= int'(ptr)) g = CW'(i);
    grant = (|req) ? NCH'(1) << g : '0;
  end
endmodule

// File: rtl/rr_mux_arb.sv
// rr_mux_arb: round-robin NCH-to-1 registered mux; ports Clock, Resetn (async low), in_data/in_valid/in_ready, out_data/out_chan/out_valid/out_ready, plus force_en/force_sel when RR_MUX_ARB_FORCE_EN is defined
module rr_mux_arb import rr_mux_pkg::*; #(
  parameter int WIDTH = 2,
  parameter int NCH = 3,
  localparam int CW = cw_of(NCH)
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [CW-1:0]        out_chan,
  output logic                 out_valid,
  input  logic                 out_ready
`ifdef RR_MUX_ARB_FORCE_EN
  ,
  input  logic                 force_en,
  input  logic [CW-1:0]        force_sel
`endif
);
  logic [CW-1:0] ptr, arb_g, g;
  logic [NCH-1:0] arb_grant, grant;
  logic [WIDTH-1:0] lane [NCH];
  logic take, hold_ptr;
  for (genvar i = 0; i < NCH; i++) begin : g_lane
    assign lane[i] = in_data[i*WIDTH +: WIDTH];
  end
  rr_arb #(.NCH(NCH), .CW(CW)) u_arb (
    .req(in_valid),
    .ptr(ptr),
    .grant(arb_grant),
    .g(arb_g)
  );
`ifdef RR_MUX_ARB_FORCE_EN
  always_comb begin
    g = force_en ? force_sel : arb_g;
    grant = force_en ? in_valid & (NCH'(1) << force_sel) : arb_grant;
    hold_ptr = force_en;
  end
`else
  always_comb begin
    g = arb_g;
    grant = arb_grant;
    hold_ptr = 1'b0;
  end
`endif
  assign take = Resetn && (!out_valid || out_ready) && (|grant);
  assign in_ready = take ? grant : '0;
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) begin
      out_valid <= RST_VALID;
      out_data <= WIDTH'(RST_DATA);
      out_chan <= CW'(RST_CHAN);
      ptr <= CW'(RST_PTR);
    end else if (take) begin
      out_valid <= 1'b1;
      out_data <= lane[g];
      out_chan <= g;
      if (!hold_ptr) ptr <= (g == CW'(NCH - 1)) ? '0 : g + 1'b1;
    end else if (out_ready) out_valid <= 1'b0;
endmodule
